// File: rtl/a_config_pkg.sv
// Shared opcodes, default field widths and FSM state type for the
// ASIC-side configuration loader.
package a_config_pkg;

  localparam int DEF_CMD_W     = 32;
  localparam int DEF_OPCODE_W  = 15;
  localparam int DEF_PAYLOAD_W = DEF_CMD_W - DEF_OPCODE_W;

  localparam int CFG_WORD     = 1;
  localparam int CFG_DONE_ACK = 2;
  localparam int CFG_RESTART  = 3;
  localparam int CFG_READ     = 4;
  localparam int CFG_ERR      = 5;

  typedef enum logic {S_LOAD, S_ACK} state_e;

endpackage

// File: rtl/a_config_loader.sv
// Assembles NUM_WORDS payload words into a shadow bank, commits them atomically
// to cfg_flat, acknowledges on the reply FIFO and serves readback/error replies.
module a_config_loader
  import a_config_pkg::*;
#(
  parameter int NUM_WORDS = 39,
  parameter int CMD_W     = DEF_CMD_W,
  parameter int OPCODE_W  = DEF_OPCODE_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                           clk_a_domain,
  input  logic                           reset,
  output logic                           fifo_d2a_command_rd_en,
  input  logic [CMD_W-1:0]               fifo_d2a_command_dout,
  input  logic                           fifo_d2a_command_empty,
  input  logic                           fifo_d2a_command_valid,
  output logic                           fifo_a2d_command_wr_en,
  output logic [CMD_W-1:0]               fifo_a2d_command_din,
  input  logic                           fifo_a2d_command_full,
  output logic [NUM_WORDS*PAYLOAD_W-1:0] cfg_flat,
  output logic                           cfg_valid,
  output logic                           cfg_commit
);

  localparam int IDX_W  = $clog2(NUM_WORDS + 1);
  localparam int BANK_W = NUM_WORDS * PAYLOAD_W;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BANK_W-1:0]    shadow_q, shadow_d;
  logic [BANK_W-1:0]    active_q, active_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 commit_q, commit_d;

  logic [OPCODE_W-1:0]  opcode;
  logic [PAYLOAD_W-1:0] payload;
  logic [PAYLOAD_W-1:0] rd_word;
  logic                 rd_in_range;

  assign opcode  = fifo_d2a_command_dout[OPCODE_W-1:0];
  assign payload = fifo_d2a_command_dout[CMD_W-1:OPCODE_W];

  // Readback always comes from the committed bank, never the shadow.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (payload == PAYLOAD_W'(i)) rd_word = active_q[i*PAYLOAD_W +: PAYLOAD_W];
    end
    rd_in_range = (payload < PAYLOAD_W'(NUM_WORDS));
  end

  always_comb begin
    state_d                = state_q;
    idx_d                  = idx_q;
    shadow_d               = shadow_q;
    active_d               = active_q;
    cfg_valid_d            = cfg_valid_q;
    commit_d               = 1'b0;
    fifo_d2a_command_rd_en = 1'b0;
    fifo_a2d_command_wr_en = 1'b0;
    fifo_a2d_command_din   = '0;
    case (state_q)
      S_LOAD: begin
        if (fifo_d2a_command_valid) begin
          if (opcode == OPCODE_W'(CFG_WORD)) begin
            fifo_d2a_command_rd_en = 1'b1;
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (idx_q == IDX_W'(i)) shadow_d[i*PAYLOAD_W +: PAYLOAD_W] = payload;
            end
            if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
              // Commit includes the word being popped this cycle.
              active_d    = shadow_d;
              commit_d    = 1'b1;
              cfg_valid_d = 1'b1;
              state_d     = S_ACK;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (opcode == OPCODE_W'(CFG_RESTART)) begin
            fifo_d2a_command_rd_en = 1'b1;
            idx_d                  = '0;
          end else if (!fifo_a2d_command_full) begin
            fifo_d2a_command_rd_en = 1'b1;
            fifo_a2d_command_wr_en = 1'b1;
            if (opcode == OPCODE_W'(CFG_READ)) begin
              fifo_a2d_command_din = rd_in_range ? {rd_word, OPCODE_W'(CFG_READ)}
                                                 : {payload, OPCODE_W'(CFG_ERR)};
            end else begin
              fifo_a2d_command_din = {PAYLOAD_W'(opcode), OPCODE_W'(CFG_ERR)};
            end
          end
        end
      end
      S_ACK: begin
        if (!fifo_a2d_command_full) begin
          fifo_a2d_command_wr_en = 1'b1;
          fifo_a2d_command_din   = {PAYLOAD_W'(NUM_WORDS), OPCODE_W'(CFG_DONE_ACK)};
          idx_d                  = '0;
          state_d                = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_a_domain) begin
    if (reset) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      cfg_valid_q <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_valid_q <= cfg_valid_d;
      commit_q    <= commit_d;
    end
  end

  assign cfg_flat   = active_q;
  assign cfg_valid  = cfg_valid_q;
  assign cfg_commit = commit_q;

  a_pop_never_empty: assert property (@(posedge clk_a_domain) disable iff (reset)
    !(fifo_d2a_command_rd_en && fifo_d2a_command_empty));

endmodule

// File: tb/tb_a_config_loader.sv
// Randomized bench for a_config_loader: a transaction-level reference model
// predicts pops, replies and the committed bank cycle by cycle.
module tb_a_config_loader;
  import a_config_pkg::*;

  localparam int NW = 39;
  localparam int PW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rd_en, valid, empty, full, wr_en, cfg_valid, cfg_commit;
  logic [31:0] dout, din;
  logic [NW*PW-1:0] cfg_flat;
  assign empty = !valid;

  a_config_loader #(.NUM_WORDS(NW)) dut (
    .clk_a_domain(clk), .reset(reset),
    .fifo_d2a_command_rd_en(rd_en), .fifo_d2a_command_dout(dout),
    .fifo_d2a_command_empty(empty), .fifo_d2a_command_valid(valid),
    .fifo_a2d_command_wr_en(wr_en), .fifo_a2d_command_din(din),
    .fifo_a2d_command_full(full),
    .cfg_flat(cfg_flat), .cfg_valid(cfg_valid), .cfg_commit(cfg_commit));

  logic v1, f1, rd1, wr1, cv1, cc1, e1;
  logic [31:0] d1, din1;
  logic [PW-1:0] flat1;
  assign e1 = !v1;
  a_config_loader #(.NUM_WORDS(1)) dut1 (
    .clk_a_domain(clk), .reset(reset),
    .fifo_d2a_command_rd_en(rd1), .fifo_d2a_command_dout(d1),
    .fifo_d2a_command_empty(e1), .fifo_d2a_command_valid(v1),
    .fifo_a2d_command_wr_en(wr1), .fifo_a2d_command_din(din1),
    .fifo_a2d_command_full(f1),
    .cfg_flat(flat1), .cfg_valid(cv1), .cfg_commit(cc1));

  logic v4, f4, rd4, wr4, cv4, cc4, e4;
  logic [31:0] d4, din4;
  logic [4*PW-1:0] flat4;
  assign e4 = !v4;
  a_config_loader #(.NUM_WORDS(4)) dut4 (
    .clk_a_domain(clk), .reset(reset),
    .fifo_d2a_command_rd_en(rd4), .fifo_d2a_command_dout(d4),
    .fifo_d2a_command_empty(e4), .fifo_d2a_command_valid(v4),
    .fifo_a2d_command_wr_en(wr4), .fifo_a2d_command_din(din4),
    .fifo_a2d_command_full(f4),
    .cfg_flat(flat4), .cfg_valid(cv4), .cfg_commit(cc4));

  int checks = 0;
  int errors = 0;

  // Reference model: payload arrays plus a word counter and "waiting to ack" flag.
  int m_shadow[NW];
  int m_active[NW];
  int m_idx;
  bit m_ack, m_cvalid, m_commit;
  logic e_rd, e_wr, o_rd, o_wr;
  logic [31:0] e_din, o_din;
  int n_commit;

  function automatic logic [31:0] mkw(input int op, input int p);
    return {17'(p), 15'(op)};
  endfunction

  function automatic logic [NW*PW-1:0] exp_flat();
    logic [NW*PW-1:0] f = '0;
    for (int i = 0; i < NW; i++) f[i*PW +: PW] = PW'(m_active[i]);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_idx = 0; m_ack = 0; m_cvalid = 0; m_commit = 0;
  endtask

  task automatic do_reset();
    valid = 0; full = 0; dout = '0;
    v1 = 0; f1 = 0; d1 = '0; v4 = 0; f4 = 0; d4 = '0;
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  // Drives one cycle, predicts the FIFO handshake from the model, samples at negedge.
  task automatic cyc(input bit v, input logic [31:0] w, input bit f);
    int op, p;
    valid = v; dout = w; full = f;
    op = int'(w[14:0]);
    p  = int'(w[31:15]);
    e_rd = 0; e_wr = 0; e_din = '0; m_commit = 0;
    if (!m_ack) begin
      if (v) begin
        if (op == 1) begin
          e_rd = 1;
          m_shadow[m_idx] = p;
          if (m_idx == NW - 1) begin
            m_active = m_shadow; m_commit = 1; m_cvalid = 1; m_ack = 1;
          end else m_idx++;
        end else if (op == 3) begin
          e_rd = 1; m_idx = 0;
        end else if (!f) begin
          e_rd = 1; e_wr = 1;
          if (op == 4) e_din = (p < NW) ? {17'(m_active[p]), 15'd4} : {17'(p), 15'd5};
          else         e_din = {17'(op), 15'd5};
        end
      end
    end else if (!f) begin
      e_wr = 1; e_din = {17'(NW), 15'd2}; m_ack = 0; m_idx = 0;
    end
    @(negedge clk);
    o_rd = rd_en; o_wr = wr_en; o_din = din;
    @(posedge clk); #1;
    if (cfg_commit === 1'b1) n_commit++;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++;
    if ({rd_en, wr_en, din} !== 34'd0) begin
      errors++;
      $display("FAIL reset_fifo rd=%b wr=%b din=%h want 0/0/0", rd_en, wr_en, din);
    end
    checks++;
    if (cfg_flat !== '0 || cfg_valid !== 1'b0 || cfg_commit !== 1'b0) begin
      errors++;
      $display("FAIL reset_cfg valid=%b commit=%b flat_nonzero=%b want 0/0/0",
               cfg_valid, cfg_commit, |cfg_flat);
    end
    checks++;
    if (flat1 !== '0 || flat4 !== '0 || cv1 !== 1'b0 || cv4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_sweep flat1=%h flat4=%h cv1=%b cv4=%b want zeros", flat1, flat4, cv1, cv4);
    end
  endtask

  task automatic test_load39();
    n_commit = 0;
    for (int i = 0; i < NW; i++) begin
      cyc(1, mkw(CFG_WORD, i + 100), 0);
      checks++;
      if (o_rd !== 1'b1 || o_wr !== 1'b0 || cfg_commit !== (i == NW - 1)) begin
        errors++;
        $display("FAIL load39_word%0d rd=%b wr=%b commit=%b want 1/0/%0d", i, o_rd, o_wr, cfg_commit, i == NW - 1);
      end
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (cfg_flat[i*PW +: PW] !== PW'(i + 100)) begin
        errors++;
        $display("FAIL load39_flat word %0d got %h want %h", i, cfg_flat[i*PW +: PW], PW'(i + 100));
      end
    end
    cyc(0, '0, 0);
    checks++;
    if (o_wr !== 1'b1 || o_din !== {17'd39, 15'd2} || o_rd !== 1'b0) begin
      errors++;
      $display("FAIL load39_ack wr=%b din=%h rd=%b want 1/%h/0", o_wr, o_din, o_rd, {17'd39, 15'd2});
    end
    checks++;
    if (n_commit !== 1 || cfg_commit !== 1'b0 || cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL load39_commits count=%0d commit=%b valid=%b want 1/0/1", n_commit, cfg_commit, cfg_valid);
    end
  endtask

  task automatic test_restart();
    n_commit = 0;
    for (int i = 0; i < 20; i++) cyc(1, mkw(CFG_WORD, int'($urandom_range(0, 17'h1FFFF))), 0);
    cyc(1, mkw(CFG_RESTART, 0), 0);
    for (int i = 0; i < NW; i++) begin
      cyc(1, mkw(CFG_WORD, 17'h1FFFF), 0);
      checks++;
      if (o_rd !== e_rd || o_wr !== e_wr || cfg_flat !== exp_flat() || cfg_commit !== m_commit) begin
        errors++;
        $display("FAIL restart_cycle%0d rd=%b wr=%b commit=%b want %b/%b/%b", i, o_rd, o_wr, cfg_commit, e_rd, e_wr, m_commit);
      end
    end
    checks++;
    if (n_commit !== 1 || cfg_flat !== {NW{17'h1FFFF}}) begin
      errors++;
      $display("FAIL restart_result commits=%0d flat_all_ones=%b want 1/1", n_commit, cfg_flat === {NW{17'h1FFFF}});
    end
    cyc(0, '0, 0);
    checks++;
    if (o_wr !== 1'b1 || o_din !== {17'd39, 15'd2}) begin
      errors++;
      $display("FAIL restart_ack wr=%b din=%h want 1/%h", o_wr, o_din, {17'd39, 15'd2});
    end
  endtask

  task automatic test_full_ack();
    int sent = 0;
    while (sent < NW - 1) begin
      if ($urandom_range(0, 3) == 0) cyc(0, '0, 0);
      else begin
        cyc(1, mkw(CFG_WORD, int'($urandom_range(0, 17'h1FFFF))), 0);
        sent++;
      end
    end
    cyc(1, mkw(CFG_WORD, 17'h0ABCD), 1);
    checks++;
    if (o_rd !== 1'b1 || o_wr !== 1'b0 || cfg_commit !== 1'b1 || cfg_flat !== exp_flat()) begin
      errors++;
      $display("FAIL fullack_last rd=%b wr=%b commit=%b want 1/0/1", o_rd, o_wr, cfg_commit);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, mkw(CFG_WORD, 7), 1);
      checks++;
      if (o_rd !== 1'b0 || o_wr !== 1'b0) begin
        errors++;
        $display("FAIL fullack_stall%0d rd=%b wr=%b want 0/0", i, o_rd, o_wr);
      end
    end
    cyc(1, mkw(CFG_WORD, 7), 0);
    checks++;
    if (o_wr !== 1'b1 || o_rd !== 1'b0 || o_din !== {17'd39, 15'd2}) begin
      errors++;
      $display("FAIL fullack_release wr=%b rd=%b din=%h want 1/0/%h", o_wr, o_rd, o_din, {17'd39, 15'd2});
    end
    valid = 0;
  endtask

  task automatic test_read();
    cyc(1, mkw(CFG_READ, 5), 0);
    checks++;
    if (o_rd !== 1'b1 || o_wr !== 1'b1 || o_din !== {17'(m_active[5]), 15'd4}) begin
      errors++;
      $display("FAIL read_p5 rd=%b wr=%b din=%h want 1/1/%h", o_rd, o_wr, o_din, {17'(m_active[5]), 15'd4});
    end
    cyc(1, mkw(CFG_READ, 39), 0);
    checks++;
    if (o_wr !== 1'b1 || o_din !== {17'd39, 15'd5}) begin
      errors++;
      $display("FAIL read_p39 wr=%b din=%h want 1/%h", o_wr, o_din, {17'd39, 15'd5});
    end
    cyc(1, mkw(7, 17'h1ABC), 0);
    checks++;
    if (o_rd !== 1'b1 || o_wr !== 1'b1 || o_din !== {17'd7, 15'd5}) begin
      errors++;
      $display("FAIL bad_opcode rd=%b wr=%b din=%h want 1/1/%h", o_rd, o_wr, o_din, {17'd7, 15'd5});
    end
    cyc(1, mkw(CFG_READ, 3), 1);
    checks++;
    if (o_rd !== 1'b0 || o_wr !== 1'b0 || o_din !== 32'd0) begin
      errors++;
      $display("FAIL read_full rd=%b wr=%b din=%h want 0/0/0", o_rd, o_wr, o_din);
    end
    for (int i = 0; i < 30; i++) begin
      cyc(1, mkw(CFG_READ, int'($urandom_range(0, 50))), $urandom_range(0, 3) == 0);
      checks++;
      if ({o_rd, o_wr, o_din} !== {e_rd, e_wr, e_din}) begin
        errors++;
        $display("FAIL read_rand%0d rd/wr/din=%b/%b/%h want %b/%b/%h", i, o_rd, o_wr, o_din, e_rd, e_wr, e_din);
      end
    end
  endtask

  task automatic test_random();
    int r, op;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      op = CFG_WORD;
      else if (r < 72) op = CFG_RESTART;
      else if (r < 85) op = CFG_READ;
      else             op = int'($urandom_range(0, 20));
      cyc($urandom_range(0, 4) != 0, mkw(op, int'($urandom_range(0, 17'h1FFFF)) % (op == CFG_READ ? 45 : 131072)),
          $urandom_range(0, 3) == 0);
      checks++;
      if ({o_rd, o_wr, o_din} !== {e_rd, e_wr, e_din} || cfg_flat !== exp_flat() ||
          cfg_commit !== m_commit || cfg_valid !== m_cvalid) begin
        errors++;
        $display("FAIL random%0d rd/wr/din=%b/%b/%h want %b/%b/%h commit=%b want %b flat_ok=%b",
                 i, o_rd, o_wr, o_din, e_rd, e_wr, e_din, cfg_commit, m_commit, cfg_flat === exp_flat());
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 30; i++) cyc(1, mkw(CFG_WORD, int'($urandom_range(0, 17'h1FFFF))), 0);
    do_reset();
    checks++;
    if (cfg_flat !== '0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_cfg valid=%b flat_nonzero=%b want 0/0", cfg_valid, |cfg_flat);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0);
      checks++;
      if (o_wr !== 1'b0) begin
        errors++;
        $display("FAIL midreset_noack%0d wr=%b want 0", i, o_wr);
      end
    end
    n_commit = 0;
    for (int i = 0; i < NW; i++) cyc(1, mkw(CFG_WORD, int'($urandom_range(0, 17'h1FFFF))), 0);
    checks++;
    if (n_commit !== 1 || cfg_flat !== exp_flat() || cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reload commits=%0d valid=%b flat_ok=%b want 1/1/1", n_commit, cfg_valid, cfg_flat === exp_flat());
    end
    cyc(0, '0, 0);
    checks++;
    if (o_wr !== 1'b1 || o_din !== {17'd39, 15'd2}) begin
      errors++;
      $display("FAIL midreset_ack wr=%b din=%h want 1/%h", o_wr, o_din, {17'd39, 15'd2});
    end
  endtask

  task automatic test_sweep();
    logic [PW-1:0] w [4];
    // NUM_WORDS=1: each word commits on its own, even with the reply FIFO full.
    for (int k = 0; k < 2; k++) begin
      w[0] = (k == 0) ? 17'h00123 : 17'h00055;
      v1 = 1; d1 = mkw(CFG_WORD, int'(w[0])); f1 = (k == 1);
      @(negedge clk);
      checks++;
      if (rd1 !== 1'b1 || wr1 !== 1'b0) begin
        errors++;
        $display("FAIL sweep1_pop%0d rd=%b wr=%b want 1/0", k, rd1, wr1);
      end
      @(posedge clk); #1;
      v1 = 0; f1 = 0;
      checks++;
      if (cc1 !== 1'b1 || cv1 !== 1'b1 || flat1 !== w[0]) begin
        errors++;
        $display("FAIL sweep1_commit%0d commit=%b valid=%b flat=%h want 1/1/%h", k, cc1, cv1, flat1, w[0]);
      end
      @(negedge clk);
      checks++;
      if (wr1 !== 1'b1 || din1 !== {17'd1, 15'd2}) begin
        errors++;
        $display("FAIL sweep1_ack%0d wr=%b din=%h want 1/%h", k, wr1, din1, {17'd1, 15'd2});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      w[i] = PW'($urandom_range(0, 17'h1FFFF));
      v4 = 1; d4 = mkw(CFG_WORD, int'(w[i])); f4 = 0;
      @(negedge clk);
      checks++;
      if (rd4 !== 1'b1) begin
        errors++;
        $display("FAIL sweep4_pop%0d rd=%b want 1", i, rd4);
      end
      @(posedge clk); #1;
      checks++;
      if (cc4 !== (i == 3)) begin
        errors++;
        $display("FAIL sweep4_commit%0d commit=%b want %0d", i, cc4, i == 3);
      end
    end
    v4 = 0;
    checks++;
    if (flat4 !== {w[3], w[2], w[1], w[0]} || cv4 !== 1'b1) begin
      errors++;
      $display("FAIL sweep4_flat got %h want %h valid=%b", flat4, {w[3], w[2], w[1], w[0]}, cv4);
    end
    @(negedge clk);
    checks++;
    if (wr4 !== 1'b1 || din4 !== {17'd4, 15'd2}) begin
      errors++;
      $display("FAIL sweep4_ack wr=%b din=%h want 1/%h", wr4, din4, {17'd4, 15'd2});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load39();
    test_restart();
    test_full_ack();
    test_read();
    test_random();
    test_midreset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
